fsm_neg_deser: RTL and testbench

FSM_NEG_DESER -- requirements
Module: fsm_neg_deser

---
 rtl/fsm_neg_deser_if.sv | 37 +++
 rtl/fsm_neg_deser.sv | 177 +++++++++++++++++
 tb/tb_fsm_neg_deser.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/fsm_neg_deser_if.sv
// Interface bundle for fsm_neg_deser: serial input side and word output side.
// Optional macro FSM_NEG_DESER_PARITY_EN adds the parity_err signal.
interface fsm_neg_deser_if #(
    parameter int WIDTH = 8
);
    logic             x;
    logic             x_vld;
    logic             sof;
    logic [WIDTH-1:0] data;
    logic             data_vld;
    logic             data_rdy;
    logic             busy;
    logic             ovf;
`ifdef FSM_NEG_DESER_PARITY_EN
    logic             parity_err;

    modport master (
        output x, x_vld, sof, data_rdy,
        input  data, data_vld, busy, ovf, parity_err
    );

    modport slave (
        input  x, x_vld, sof, data_rdy,
        output data, data_vld, busy, ovf, parity_err
    );
`else
    modport master (
        output x, x_vld, sof, data_rdy,
        input  data, data_vld, busy, ovf
    );

    modport slave (
        input  x, x_vld, sof, data_rdy,
        output data, data_vld, busy, ovf
    );
`endif
endinterface

// File: rtl/fsm_neg_deser.sv
// Serial deserializer that recovers a word sent LSB first as its two's-complement
// negation. Decoding uses the classic copy-until-first-one, then-invert rule.
// Optional macro FSM_NEG_DESER_PARITY_EN appends an even-parity bit to each frame.
module fsm_neg_deser #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    fsm_neg_deser_if.slave bus
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

`ifdef FSM_NEG_DESER_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COPY   = 2'd1,
        ST_INVERT = 2'd2,
        ST_PARITY = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COPY   = 2'd1,
        ST_INVERT = 2'd2
    } state_t;
`endif

    state_t           state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic [WIDTH-1:0] shift_r, shift_nxt_s;
    logic [WIDTH-1:0] word_s;
    logic [WIDTH-1:0] data_r;
    logic             data_vld_r;
    logic             ovf_r;
    logic             done_s;
    logic             bit_s;
`ifdef FSM_NEG_DESER_PARITY_EN
    logic             par_r, par_nxt_s;
    logic             perr_s;
    logic             perr_r;
`endif

    // Frame state, bit counter and shift register advance on accepted bits only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            shift_r <= '0;
`ifdef FSM_NEG_DESER_PARITY_EN
            par_r   <= 1'b0;
`endif
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            shift_r <= shift_nxt_s;
`ifdef FSM_NEG_DESER_PARITY_EN
            par_r   <= par_nxt_s;
`endif
        end
    end

    // Next-state decode: sof always restarts the frame; otherwise copy/invert per state.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        shift_nxt_s = shift_r;
        done_s      = 1'b0;
        word_s      = shift_r;
        bit_s       = 1'b0;
`ifdef FSM_NEG_DESER_PARITY_EN
        par_nxt_s   = par_r;
        perr_s      = 1'b0;
`endif
        if (bus.x_vld == 1'b1) begin
            if (bus.sof == 1'b1) begin
                // First bit is decoded as in COPY; a 1 here starts the inversion.
                bit_s       = bus.x;
                shift_nxt_s = {bit_s, shift_r[WIDTH-1:1]};
                cnt_nxt_s   = CNT_W'(1);
                state_nxt_s = (bus.x == 1'b1) ? ST_INVERT : ST_COPY;
`ifdef FSM_NEG_DESER_PARITY_EN
                par_nxt_s   = bus.x;
`endif
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        state_nxt_s = ST_IDLE;
                    end
                    ST_COPY, ST_INVERT: begin
                        bit_s       = (state_r == ST_INVERT) ? ~bus.x : bus.x;
                        shift_nxt_s = {bit_s, shift_r[WIDTH-1:1]};
`ifdef FSM_NEG_DESER_PARITY_EN
                        par_nxt_s   = par_r ^ bus.x;
`endif
                        if (cnt_r == LAST_BIT) begin
                            cnt_nxt_s = '0;
`ifdef FSM_NEG_DESER_PARITY_EN
                            state_nxt_s = ST_PARITY;
`else
                            state_nxt_s = ST_IDLE;
                            done_s      = 1'b1;
                            word_s      = shift_nxt_s;
`endif
                        end else begin
                            cnt_nxt_s = cnt_r + CNT_W'(1);
                            if ((state_r == ST_COPY) && (bus.x == 1'b1)) begin
                                state_nxt_s = ST_INVERT;
                            end else begin
                                state_nxt_s = state_r;
                            end
                        end
                    end
`ifdef FSM_NEG_DESER_PARITY_EN
                    ST_PARITY: begin
                        // Even parity: data bits plus parity bit must XOR to zero.
                        state_nxt_s = ST_IDLE;
                        done_s      = 1'b1;
                        word_s      = shift_r;
                        perr_s      = par_r ^ bus.x;
                    end
`endif
                    default: begin
                        state_nxt_s = ST_IDLE;
                        cnt_nxt_s   = '0;
                    end
                endcase
            end
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Output word holding register with consumer handshake and sticky overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_r     <= '0;
            data_vld_r <= 1'b0;
            ovf_r      <= 1'b0;
`ifdef FSM_NEG_DESER_PARITY_EN
            perr_r     <= 1'b0;
`endif
        end else if (done_s) begin
            if (!data_vld_r || bus.data_rdy) begin
                data_r     <= word_s;
                data_vld_r <= 1'b1;
`ifdef FSM_NEG_DESER_PARITY_EN
                perr_r     <= perr_s;
`endif
            end else begin
                // Previous word still unaccepted: keep it, drop the new one.
                ovf_r      <= 1'b1;
`ifdef FSM_NEG_DESER_PARITY_EN
                perr_r     <= 1'b0;
`endif
            end
        end else begin
            if (data_vld_r && bus.data_rdy) begin
                data_vld_r <= 1'b0;
            end else begin
                data_vld_r <= data_vld_r;
            end
`ifdef FSM_NEG_DESER_PARITY_EN
            perr_r <= 1'b0;
`endif
        end
    end

    assign bus.data     = data_r;
    assign bus.data_vld = data_vld_r;
    assign bus.ovf      = ovf_r;
    assign bus.busy     = (state_r != ST_IDLE);
`ifdef FSM_NEG_DESER_PARITY_EN
    assign bus.parity_err = perr_r;
`endif

endmodule

// File: tb/tb_fsm_neg_deser.sv
// Self-checking bench for fsm_neg_deser (WIDTH=8). Reference model works on whole
// frames: the received raw bits form an integer and the expected word is its negation.
// Works in both builds; parity checks are added when FSM_NEG_DESER_PARITY_EN is set.
`timescale 1ns/1ps
module tb_fsm_neg_deser;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    fsm_neg_deser_if #(.WIDTH(W)) bus ();

    fsm_neg_deser #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;
    int vld_seen = 0;

    // Reference model state
    logic         m_active;
    int           m_bits;
    logic [W-1:0] m_raw;
    logic [W-1:0] m_data;
    logic         m_vld;
    logic         m_ovf;
    logic         m_perr;

    // Apply one cycle of inputs, advance the model, sample outputs #1 after the edge.
    task automatic step(input logic r, input logic v, input logic s,
                        input logic xb, input logic rdy);
        logic         done;
        logic         perr;
        logic [W-1:0] word;
        rst_n = r; bus.x_vld = v; bus.sof = s; bus.x = xb; bus.data_rdy = rdy;
        @(posedge clk);
        done = 1'b0; perr = 1'b0; word = '0;
        if (!r) begin
            m_active = 1'b0; m_bits = 0; m_raw = '0;
            m_data = '0; m_vld = 1'b0; m_ovf = 1'b0; m_perr = 1'b0;
        end else begin
            if (v) begin
                if (s) begin
                    m_active = 1'b1; m_raw = '0; m_raw[0] = xb; m_bits = 1;
                end else if (m_active) begin
                    if (m_bits < W) begin
                        m_raw[m_bits] = xb;
                        m_bits++;
`ifndef FSM_NEG_DESER_PARITY_EN
                        if (m_bits == W) begin
                            done = 1'b1; m_active = 1'b0;
                        end
`endif
                    end else begin
                        done = 1'b1; m_active = 1'b0;
                        perr = ($countones(m_raw) + int'(xb)) % 2 != 0;
                    end
                end
            end
            word = '0 - m_raw;
            if (done) begin
                if (!m_vld || rdy) begin
                    m_data = word; m_vld = 1'b1; m_perr = perr;
                end else begin
                    m_ovf = 1'b1; m_perr = 1'b0;
                end
            end else begin
                if (m_vld && rdy) m_vld = 1'b0;
                m_perr = 1'b0;
            end
        end
        #1;
        if (bus.data_vld === 1'b1) vld_seen++;
    endtask

    // Send one complete frame (plus correct parity bit when enabled).
    task automatic send_word(input logic [W-1:0] raw, input logic rdy);
        for (int i = 0; i < W; i++) step(1'b1, 1'b1, (i == 0), raw[i], rdy);
`ifdef FSM_NEG_DESER_PARITY_EN
        step(1'b1, 1'b1, 1'b0, ^raw, rdy);
`endif
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        n_vec++; if (bus.data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", bus.data); end
        n_vec++; if (bus.data_vld !== 1'b0) begin n_err++; $display("FAIL reset_vld: got %b want 0", bus.data_vld); end
        n_vec++; if (bus.ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", bus.ovf); end
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_fb();
        do_reset();
        send_word(8'hFB, 1'b0);
        n_vec++; if (bus.data !== 8'h05) begin n_err++; $display("FAIL fb_data: got %h want 05", bus.data); end
        n_vec++; if (bus.data_vld !== 1'b1) begin n_err++; $display("FAIL fb_vld: got %b want 1", bus.data_vld); end
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL fb_busy: got %b want 0", bus.busy); end
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        n_vec++; if (bus.data_vld !== 1'b1) begin n_err++; $display("FAIL fb_hold: got %b want 1", bus.data_vld); end
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        n_vec++; if (bus.data_vld !== 1'b0) begin n_err++; $display("FAIL fb_accept: got %b want 0", bus.data_vld); end
    endtask

    task automatic test_zero_80();
        do_reset();
        send_word(8'h00, 1'b1);
        n_vec++; if (bus.data !== 8'h00 || bus.data_vld !== 1'b1) begin n_err++; $display("FAIL zero_word: got %h/%b want 00/1", bus.data, bus.data_vld); end
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        n_vec++; if (bus.data_vld !== 1'b0) begin n_err++; $display("FAIL zero_pulse: got %b want 0", bus.data_vld); end
        send_word(8'h80, 1'b1);
        n_vec++; if (bus.data !== 8'h80 || bus.data_vld !== 1'b1) begin n_err++; $display("FAIL w80_word: got %h/%b want 80/1", bus.data, bus.data_vld); end
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        n_vec++; if (bus.data_vld !== 1'b0) begin n_err++; $display("FAIL w80_pulse: got %b want 0", bus.data_vld); end
    endtask

    task automatic test_overflow();
        do_reset();
        send_word(8'hFB, 1'b0);
        send_word(8'hFE, 1'b0);
        n_vec++; if (bus.data !== 8'h05) begin n_err++; $display("FAIL ovf_data: got %h want 05", bus.data); end
        n_vec++; if (bus.ovf !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", bus.ovf); end
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        n_vec++; if (bus.data_vld !== 1'b0 || bus.ovf !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got vld %b ovf %b want 0/1", bus.data_vld, bus.ovf); end
    endtask

    task automatic test_restart();
        logic [W-1:0] fb;
        fb = 8'hFB;
        do_reset();
        vld_seen = 0;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, (i == 0), fb[i], 1'b1);
        send_word(8'hFF, 1'b1);
        n_vec++; if (bus.data !== 8'h01) begin n_err++; $display("FAIL restart_data: got %h want 01", bus.data); end
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        n_vec++; if (vld_seen !== 1 || bus.ovf !== 1'b0) begin n_err++; $display("FAIL restart_once: got %0d words ovf %b want 1/0", vld_seen, bus.ovf); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        vld_seen = 0;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, (i == 0), 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
        for (int i = 0; i < W; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        send_word(8'hFE, 1'b1);
        n_vec++; if (bus.data !== 8'h02) begin n_err++; $display("FAIL rstmid_data: got %h want 02", bus.data); end
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        n_vec++; if (vld_seen !== 1 || bus.ovf !== 1'b0) begin n_err++; $display("FAIL rstmid_once: got %0d words ovf %b want 1/0", vld_seen, bus.ovf); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] raw;
        logic [W-1:0] exp_w;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            raw = W'($urandom);
            exp_w = '0 - raw;
            send_word(raw, 1'b1);
            n_vec++; if (bus.data !== exp_w || bus.data_vld !== 1'b1) begin n_err++; $display("FAIL b2b_word%0d: got %h/%b want %h/1", k, bus.data, bus.data_vld, exp_w); end
        end
        n_vec++; if (bus.ovf !== 1'b0) begin n_err++; $display("FAIL b2b_ovf: got %b want 0", bus.ovf); end
    endtask

`ifdef FSM_NEG_DESER_PARITY_EN
    task automatic test_parity();
        logic [W-1:0] fb;
        fb = 8'hFB;
        do_reset();
        for (int i = 0; i < W; i++) step(1'b1, 1'b1, (i == 0), fb[i], 1'b0);
        n_vec++; if (bus.data_vld !== 1'b0 || bus.busy !== 1'b1) begin n_err++; $display("FAIL par_wait: got vld %b busy %b want 0/1", bus.data_vld, bus.busy); end
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        n_vec++; if (bus.data !== 8'h05 || bus.data_vld !== 1'b1) begin n_err++; $display("FAIL par_word: got %h/%b want 05/1", bus.data, bus.data_vld); end
        n_vec++; if (bus.parity_err !== 1'b1) begin n_err++; $display("FAIL par_err: got %b want 1", bus.parity_err); end
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        n_vec++; if (bus.parity_err !== 1'b0) begin n_err++; $display("FAIL par_pulse: got %b want 0", bus.parity_err); end
        send_word(8'hFB, 1'b1);
        n_vec++; if (bus.parity_err !== 1'b0 || bus.data_vld !== 1'b1) begin n_err++; $display("FAIL par_good: got err %b vld %b want 0/1", bus.parity_err, bus.data_vld); end
    endtask
`endif

    task automatic test_random();
        logic r, v, s, xb, rdy;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            r   = ($urandom_range(0, 299) != 0);
            v   = ($urandom_range(0, 3) != 0);
            s   = ($urandom_range(0, 14) == 0);
            xb  = 1'($urandom);
            rdy = ($urandom_range(0, 2) != 0);
            step(r, v, s, xb, rdy);
            n_vec++; if (bus.data !== m_data) begin n_err++; $display("FAIL rnd_data@%0d: got %h want %h", c, bus.data, m_data); end
            n_vec++; if (bus.data_vld !== m_vld) begin n_err++; $display("FAIL rnd_vld@%0d: got %b want %b", c, bus.data_vld, m_vld); end
            n_vec++; if (bus.ovf !== m_ovf) begin n_err++; $display("FAIL rnd_ovf@%0d: got %b want %b", c, bus.ovf, m_ovf); end
            n_vec++; if (bus.busy !== m_active) begin n_err++; $display("FAIL rnd_busy@%0d: got %b want %b", c, bus.busy, m_active); end
`ifdef FSM_NEG_DESER_PARITY_EN
            n_vec++; if (bus.parity_err !== m_perr) begin n_err++; $display("FAIL rnd_perr@%0d: got %b want %b", c, bus.parity_err, m_perr); end
`endif
        end
    endtask

    initial begin
        rst_n = 1'b0; bus.x = 1'b0; bus.x_vld = 1'b0; bus.sof = 1'b0; bus.data_rdy = 1'b0;
        m_active = 1'b0; m_bits = 0; m_raw = '0;
        m_data = '0; m_vld = 1'b0; m_ovf = 1'b0; m_perr = 1'b0;
        test_reset();
        test_fb();
        test_zero_80();
        test_overflow();
        test_restart();
        test_reset_mid();
        test_back_to_back();
`ifdef FSM_NEG_DESER_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
